// File: rtl/hs_timer_pkg.sv
// Shared types and constants for the HS interval timer.
// State encoding, default widths and D-PHY interval tick counts.
package hs_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } hs_state_t;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_PRESCALE_W = 4;

   // Interval lengths in timer ticks, loaded by the HS control FSM as max_count.
   localparam int LPX_TICKS        = 6;
   localparam int HS_PREPARE_TICKS = 5;
   localparam int HS_ZERO_TICKS    = 17;
   localparam int HS_TRAIL_TICKS   = 8;

endpackage

// File: rtl/hs_timer_prescaler.sv
// Tick divider for hs_timer: tick is high when the divider reaches terminal,
// after which it wraps to 0. Clear wins over hold.
module hs_timer_prescaler #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         hold,
   input  logic [W-1:0] terminal,
   output logic         tick
);

   logic [W-1:0] presc_reg;

   assign tick = (presc_reg == terminal);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_reg <= '0;
      end else if (clear) begin
         presc_reg <= '0;
      end else if (!hold) begin
         presc_reg <= tick ? '0 : presc_reg + W'(1);
      end
   end

endmodule

// File: rtl/hs_timer.sv
// Programmable interval timer (one-shot / auto-reload, pause, abort).
// Define HS_TIMER_PRESCALE_EN to add the prescale port and tick divider.
module hs_timer
   import hs_timer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic                  mode,
   input  logic [WIDTH-1:0]      max_count,
`ifdef HS_TIMER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [WIDTH-1:0]      count
);

   hs_state_t        state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] max_q_reg;
   logic             mode_q_reg;
   logic             done_reg, done_next;
   logic             err_reg, err_next;
   logic             load;
   logic             start_ok;
   logic             tick;
   logic [WIDTH-1:0] last_count;

   assign start_ok   = start && (max_count != '0);
   assign last_count = max_q_reg - WIDTH'(1);

`ifdef HS_TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale_q_reg;
   logic                  presc_clear;
   logic                  presc_hold;

   // A rejected start (max_count == 0) also freezes the divider for that cycle.
   assign presc_clear = stop || start_ok || (state_reg == IDLE);
   assign presc_hold  = start || pause;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prescale_q_reg <= '0;
      end else if (!stop && load) begin
         prescale_q_reg <= prescale;
      end
   end

   hs_timer_prescaler #(
      .W (PRESCALE_W)
   ) u_prescaler (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (presc_clear),
      .hold     (presc_hold),
      .terminal (prescale_q_reg),
      .tick     (tick)
   );
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      load       = 1'b0;
      if (stop) begin
         state_next = IDLE;
         count_next = '0;
      end else if (start) begin
         if (start_ok) begin
            load       = 1'b1;
            state_next = RUN;
            count_next = '0;
         end else begin
            err_next = 1'b1;
         end
      end else if (state_reg != IDLE) begin
         if (pause) begin
            state_next = HOLD;
         end else begin
            // Leaving HOLD counts on the same edge, so each paused cycle costs one clock.
            state_next = RUN;
            if (tick) begin
               if (count_reg == last_count) begin
                  count_next = '0;
                  done_next  = 1'b1;
                  state_next = mode_q_reg ? RUN : IDLE;
               end else begin
                  count_next = count_reg + WIDTH'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         max_q_reg  <= '0;
         mode_q_reg <= 1'b0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         if (load) begin
            max_q_reg  <= max_count;
            mode_q_reg <= mode;
         end
      end
   end

   assign busy  = (state_reg != IDLE);
   assign done  = done_reg;
   assign err   = err_reg;
   assign count = count_reg;

endmodule
